// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I core memory path: default widths,
// response owner encoding and the legal byte-enable masks.
package cpu_pkg;

    localparam int CPU_WORD_SIZE = 32;
    localparam int CPU_ADDR_SIZE = 10;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;

    // Read response tag carried one cycle alongside the RAM access.
    typedef struct packed {
        logic owner;
        logic valid;
    } resp_tag_t;

endpackage

// File: rtl/be_align_check.sv
// Legality of a byte-enable mask against the low address bits.
// Shared by the arbiter and the load/store unit.
module be_align_check
    import cpu_pkg::*;
(
    input  logic [3:0] be,
    input  logic [1:0] addr_lo,
    output logic       legal
);

    // Word needs a word-aligned address, halves need an even address,
    // single bytes go anywhere; every other mask is rejected.
    always_comb begin
        legal = 1'b0;
        case (be)
            BE_WORD:                            legal = (addr_lo == 2'b00);
            BE_HALF_LO, BE_HALF_HI:             legal = ~addr_lo[0];
            4'b0001, 4'b0010, 4'b0100, 4'b1000: legal = 1'b1;
            default:                            legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between instruction
// fetch and data access. Data side wins contention until fetch has lost
// STARVE_LIMIT consecutive cycles, then fetch is forced through.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int WORD_SIZE    = CPU_WORD_SIZE,
    parameter int ADDR_SIZE    = CPU_ADDR_SIZE,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   if_req,
    input  logic [ADDR_SIZE-1:0]   if_addr,
    output logic                   if_gnt,
    output logic                   if_rvalid,
    output logic [WORD_SIZE-1:0]   if_rdata,

    input  logic                   d_req,
    input  logic                   d_we,
    input  logic [3:0]             d_be,
    input  logic [ADDR_SIZE-1:0]   d_addr,
    input  logic [WORD_SIZE-1:0]   d_wdata,
    output logic                   d_gnt,
    output logic                   d_rvalid,
    output logic [WORD_SIZE-1:0]   d_rdata,
    output logic                   d_misalign,

    output logic                   ram_en,
    output logic [3:0]             ram_we,
    output logic [ADDR_SIZE-3:0]   ram_addr,
    output logic [WORD_SIZE-1:0]   ram_wdata,
    input  logic [WORD_SIZE-1:0]   ram_rdata,

    output logic                   stall_if,
    output logic                   stall_mem
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]           starve_cnt;
    logic                 starved;
    logic                 d_legal;
    logic                 d_access;
    logic                 rd_grant;
    resp_tag_t            tag;
    logic                 misalign_q;
    logic                 if_take;
    logic                 d_take;
    logic [WORD_SIZE-1:0] if_rdata_q;
    logic [WORD_SIZE-1:0] d_rdata_q;

    // Fetch addresses are always word aligned; the low bits carry nothing.
    logic unused_if_addr_lo;
    assign unused_if_addr_lo = ^if_addr[1:0];

    be_align_check u_be_check (
        .be      (d_be),
        .addr_lo (d_addr[1:0]),
        .legal   (d_legal)
    );

    assign starved = (starve_cnt == LIMIT);

    // Grants are mutually exclusive and suppressed entirely during reset.
    assign if_gnt    = ~rst & if_req & (~d_req | starved);
    assign d_gnt     = ~rst & d_req & ~(if_req & starved);
    assign stall_if  = ~rst & if_req & ~if_gnt;
    assign stall_mem = ~rst & d_req & ~d_gnt;

    // A misaligned data request is accepted but never touches the RAM.
    assign d_access = d_gnt & d_legal;
    assign rd_grant = if_gnt | (d_access & ~d_we);

    // Drive the RAM from whichever side owns this cycle.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 4'b0000;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!rst) ram_wdata = d_wdata;
        if (d_access) begin
            ram_en   = 1'b1;
            ram_addr = d_addr[ADDR_SIZE-1:2];
            if (d_we) ram_we = d_be;
        end else if (if_gnt) begin
            ram_en   = 1'b1;
            ram_addr = if_addr[ADDR_SIZE-1:2];
        end
    end

    // Count consecutive cycles fetch was left waiting; a fetch grant clears it.
    always_ff @(posedge clk) begin
        if (rst)                        starve_cnt <= 4'd0;
        else if (if_gnt)                starve_cnt <= 4'd0;
        else if (if_req && !starved)    starve_cnt <= starve_cnt + 4'd1;
    end

    // Tag each read with its owner; also remember misaligned acceptances.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag        <= '0;
            misalign_q <= 1'b0;
        end else begin
            tag.valid  <= rd_grant;
            tag.owner  <= d_gnt ? OWN_D : OWN_IF;
            misalign_q <= d_gnt & ~d_legal;
        end
    end

    // Reset gates the returning response so a read in flight is dropped.
    assign if_take = ~rst & tag.valid & (tag.owner == OWN_IF);
    assign d_take  = ~rst & tag.valid & (tag.owner == OWN_D);

    // Hold each side's last read word so the non-owner output stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (if_take) if_rdata_q <= ram_rdata;
            if (d_take)  d_rdata_q  <= ram_rdata;
        end
    end

    assign if_rvalid  = if_take;
    assign d_rvalid   = d_take;
    assign if_rdata   = rst ? '0 : (if_take ? ram_rdata : if_rdata_q);
    assign d_rdata    = rst ? '0 : (d_take ? ram_rdata : d_rdata_q);
    assign d_misalign = ~rst & misalign_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [9:0]  if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [9:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt, d_rvalid, d_misalign;
    logic [31:0] d_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        stall_if, stall_mem;

    logic [31:0] mem [0:255];
    int          errs   = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WORD_SIZE(32), .ADDR_SIZE(10), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_misalign(d_misalign),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    // Single-port synchronous RAM with byte writes.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        if_req  = 1'b0; if_addr = '0;
        d_req   = 1'b0; d_we = 1'b0; d_be = 4'b1111; d_addr = '0; d_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'h5566_7788;
        mem[1] = 32'h0000_00A0;
        mem[2] = 32'h0000_00A1;
        mem[3] = 32'h0000_00A2;
        mem[4] = 32'hDEAD_BEEF;
        mem[8] = 32'h1122_3344;
        ram_rdata = '0;
        idle();
        rst = 1'b1;
        if_req = 1'b1; if_addr = 10'h004;
        tick(); tick();

        // Reset state: everything quiet even with a pending fetch.
        chk("rst_if_gnt",   32'(if_gnt), 0);
        chk("rst_ram_en",   32'(ram_en), 0);
        chk("rst_stall_if", 32'(stall_if), 0);
        chk("rst_if_rv",    32'(if_rvalid), 0);
        chk("rst_d_rv",     32'(d_rvalid), 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata",  d_rdata, 0);
        chk("rst_misalign", 32'(d_misalign), 0);
        rst = 1'b0;
        idle();
        #1;
        chk("idle_ram_en", 32'(ram_en), 0);
        chk("idle_ram_we", 32'(ram_we), 0);
        tick();

        // Fetch only, back to back.
        for (int i = 0; i < 3; i++) begin
            if_req = 1'b1; if_addr = 10'(4 * (i + 1));
            #1;
            chk("ifo_gnt",   32'(if_gnt), 1);
            chk("ifo_addr",  32'(ram_addr), 32'(i + 1));
            chk("ifo_stall", 32'(stall_if), 0);
            tick();
            chk("ifo_rv",    32'(if_rvalid), 1);
            chk("ifo_rdata", if_rdata, 32'hA0 + 32'(i));
        end

        // Contention: data load beats fetch.
        if_req = 1'b1; if_addr = 10'h040;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'b1111; d_addr = 10'h010;
        #1;
        chk("con_d_gnt",    32'(d_gnt), 1);
        chk("con_if_gnt",   32'(if_gnt), 0);
        chk("con_stall_if", 32'(stall_if), 1);
        chk("con_ram_addr", 32'(ram_addr), 4);
        tick();
        chk("con_d_rv",    32'(d_rvalid), 1);
        chk("con_d_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("con_if_rv",   32'(if_rvalid), 0);
        chk("con_if_hold", if_rdata, 32'hA2);

        // Let fetch through alone so the starvation count restarts at zero.
        d_req = 1'b0;
        #1;
        chk("clr_if_gnt", 32'(if_gnt), 1);
        tick();

        // Starvation: both held high, fetch forced every fifth cycle.
        d_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("stv_d_gnt",     32'(d_gnt), (k % 5 == 4) ? 0 : 1);
            chk("stv_if_gnt",    32'(if_gnt), (k % 5 == 4) ? 1 : 0);
            chk("stv_stall_mem", 32'(stall_mem), (k % 5 == 4) ? 1 : 0);
            tick();
        end
        idle();
        tick();

        // Byte store into word 8, lane 2.
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0100; d_addr = 10'h022; d_wdata = 32'h00AB_0000;
        #1;
        chk("st_gnt",  32'(d_gnt), 1);
        chk("st_we",   32'(ram_we), 32'h4);
        chk("st_addr", 32'(ram_addr), 8);
        tick();
        chk("st_no_rv", 32'(d_rvalid), 0);
        d_we = 1'b0; d_be = 4'b1111; d_addr = 10'h020; d_wdata = '0;
        tick();
        chk("st_ld_rv",    32'(d_rvalid), 1);
        chk("st_ld_rdata", d_rdata, 32'h11AB_3344);

        // Misaligned word store: accepted, no RAM access, flagged next cycle.
        d_we = 1'b1; d_be = 4'b1111; d_addr = 10'h002; d_wdata = 32'hFFFF_FFFF;
        #1;
        chk("mis_gnt",    32'(d_gnt), 1);
        chk("mis_ram_en", 32'(ram_en), 0);
        chk("mis_ram_we", 32'(ram_we), 0);
        tick();
        chk("mis_flag",  32'(d_misalign), 1);
        chk("mis_no_rv", 32'(d_rvalid), 0);
        // Misaligned half load: also blocked.
        d_we = 1'b0; d_be = 4'b0011; d_addr = 10'h001; d_wdata = '0;
        #1;
        chk("mish_ram_en", 32'(ram_en), 0);
        tick();
        chk("mish_flag",  32'(d_misalign), 1);
        chk("mish_no_rv", 32'(d_rvalid), 0);
        // Legal word load of word 0: contents unchanged, flag cleared.
        d_be = 4'b1111; d_addr = 10'h000;
        #1;
        chk("chk_ram_en", 32'(ram_en), 1);
        tick();
        chk("mis_clear",  32'(d_misalign), 0);
        chk("mis_intact", d_rdata, 32'h5566_7788);
        idle();
        tick();

        // Reset lands while a fetch read is in flight.
        if_req = 1'b1; if_addr = 10'h004;
        #1;
        chk("rr_gnt", 32'(if_gnt), 1);
        tick();
        rst = 1'b1;
        #1;
        chk("rr_rv_n1",    32'(if_rvalid), 0);
        chk("rr_gnt_rst",  32'(if_gnt), 0);
        chk("rr_en_rst",   32'(ram_en), 0);
        chk("rr_stall",    32'(stall_if), 0);
        chk("rr_rdata",    if_rdata, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rr_rv_n2",  32'(if_rvalid), 0);
        chk("rr_resume", 32'(if_gnt), 1);
        tick();
        chk("rr_rv_after", 32'(if_rvalid), 1);
        chk("rr_rdata_after", if_rdata, 32'hA0);
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
